// File: rtl/ipf_sequencer.sv
// Streams one weight set and an 8-word input tile into IPF and schedules its passes.
// Latency: tags are registered, so IPF strobes align with mem_rdata one cycle after each read.
// Backpressure: none; memory answers in fixed time and IPF never stalls. Abort ends a job at once.
module ipf_sequencer #(
    parameter int AW     = 16,
    parameter int DW     = 64,
    parameter int DRAIN  = 10,
    parameter int FIN_TO = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [1:0]    cfg_wsize,
    input  logic          cfg_stride,
    input  logic [1:0]    cfg_padding,
    input  logic [AW-1:0] cfg_w_base,
    input  logic [AW-1:0] cfg_i_base,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    output logic          ipf_w_valid,
    output logic [DW-1:0] ipf_w_data,
    output logic          ipf_i_valid,
    output logic [DW-1:0] ipf_i_data,
    output logic [1:0]    ipf_ctrl,
    output logic [1:0]    ipf_wsize,
    output logic          ipf_stride,
    output logic [1:0]    ipf_rlpadding,
    output logic [3:0]    ipf_wgroup,
    output logic [2:0]    ipf_wround,
    input  logic          ipf_finish
);
    localparam int CW = $clog2(FIN_TO + DRAIN + 32) + 1;

    localparam logic [1:0] CTRL_END   = 2'd0;
    localparam logic [1:0] CTRL_START = 2'd1;
    localparam logic [1:0] CTRL_HOLD  = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_W, S_PRELOAD, S_RUN, S_DRAIN, S_END_WAIT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    pass_q, pass_d;

    logic [1:0]    wsize_q, padding_q;
    logic          stride_q;
    logic [AW-1:0] w_base_q, i_base_q;
    logic          cfg_take;

    logic          w_vld_d, i_vld_d, done_d, err_d;
    logic [1:0]    ctrl_d;
    logic [3:0]    wgroup_d;
    logic [2:0]    wround_d;

    logic [CW-1:0] nw_last, p_len;
    logic [1:0]    npass_last;
    logic [3:0]    pass_wg;
    logic [2:0]    pass_wr;
    logic          run_odd;

    always_comb begin
        nw_last    = (wsize_q == 2'd0) ? CW'(17) : CW'(24);
        p_len      = (wsize_q == 2'd0) ? CW'(2) : (wsize_q == 2'd1) ? CW'(4) : CW'(6);
        npass_last = stride_q ? 2'd0 : (wsize_q == 2'd2) ? 2'd3 : 2'd1;
        pass_wg    = (!stride_q && wsize_q == 2'd0) ? 4'(pass_q) : 4'd0;
        pass_wr    = (!stride_q && wsize_q != 2'd0) ? 3'(pass_q) : 3'd0;
        // Parity of (cnt - P): P is the offset of the first RUN word in the tile.
        run_odd    = cnt_q[0] ^ p_len[0];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pass_d    = pass_q;
        cfg_take  = 1'b0;
        w_vld_d   = 1'b0;
        i_vld_d   = 1'b0;
        ctrl_d    = CTRL_HOLD;
        wgroup_d  = 4'd0;
        wround_d  = 3'd0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        mem_rd_en = 1'b0;
        mem_addr  = '0;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    if (cfg_wsize == 2'd3) begin
                        err_d = 1'b1;
                    end else begin
                        cfg_take = 1'b1;
                        state_d  = S_LOAD_W;
                        cnt_d    = '0;
                        pass_d   = 2'd0;
                    end
                end
            end
            S_LOAD_W: begin
                mem_rd_en = 1'b1;
                mem_addr  = w_base_q + AW'(cnt_q);
                w_vld_d   = 1'b1;
                if (cnt_q == nw_last) begin
                    state_d = S_PRELOAD;
                    cnt_d   = '0;
                    pass_d  = 2'd0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PRELOAD: begin
                mem_rd_en = 1'b1;
                mem_addr  = i_base_q + AW'(cnt_q);
                i_vld_d   = 1'b1;
                wgroup_d  = pass_wg;
                wround_d  = pass_wr;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == p_len - 1'b1)
                    state_d = S_RUN;
            end
            S_RUN: begin
                mem_rd_en = 1'b1;
                mem_addr  = i_base_q + AW'(cnt_q);
                i_vld_d   = 1'b1;
                ctrl_d    = CTRL_START;
                wgroup_d  = stride_q ? {3'd0, run_odd} : pass_wg;
                wround_d  = pass_wr;
                if (cnt_q == CW'(7)) begin
                    cnt_d = '0;
                    if (pass_q != npass_last) begin
                        pass_d  = pass_q + 1'b1;
                        state_d = S_PRELOAD;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (cnt_q == CW'(DRAIN - 1)) begin
                    cnt_d   = '0;
                    state_d = S_END_WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_END_WAIT: begin
                ctrl_d = CTRL_END;
                if (ipf_finish) begin
                    done_d  = 1'b1;
                    ctrl_d  = CTRL_HOLD;
                    state_d = S_IDLE;
                end else if (cnt_q == CW'(FIN_TO - 1)) begin
                    err_d   = 1'b1;
                    ctrl_d  = CTRL_HOLD;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything, including the tag of a read issued this cycle.
        if (abort && state_q != S_IDLE) begin
            state_d  = S_IDLE;
            w_vld_d  = 1'b0;
            i_vld_d  = 1'b0;
            ctrl_d   = CTRL_END;
            wgroup_d = 4'd0;
            wround_d = 3'd0;
            done_d   = 1'b0;
            err_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            pass_q      <= 2'd0;
            wsize_q     <= 2'd0;
            stride_q    <= 1'b0;
            padding_q   <= 2'd0;
            w_base_q    <= '0;
            i_base_q    <= '0;
            ipf_w_valid <= 1'b0;
            ipf_i_valid <= 1'b0;
            ipf_ctrl    <= CTRL_HOLD;
            ipf_wgroup  <= 4'd0;
            ipf_wround  <= 3'd0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pass_q      <= pass_d;
            if (cfg_take) begin
                wsize_q   <= cfg_wsize;
                stride_q  <= cfg_stride;
                padding_q <= cfg_padding;
                w_base_q  <= cfg_w_base;
                i_base_q  <= cfg_i_base;
            end
            ipf_w_valid <= w_vld_d;
            ipf_i_valid <= i_vld_d;
            ipf_ctrl    <= ctrl_d;
            ipf_wgroup  <= wgroup_d;
            ipf_wround  <= wround_d;
            done        <= done_d;
            err         <= err_d;
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign ipf_wsize     = wsize_q;
    assign ipf_stride    = stride_q;
    assign ipf_rlpadding = padding_q;
    assign ipf_w_data    = ipf_w_valid ? mem_rdata : '0;
    assign ipf_i_data    = ipf_i_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_ipf_sequencer.sv
// Scoreboard bench for ipf_sequencer: expected IPF beats are queued per job and popped as the DUT emits them.
module tb_ipf_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0, abort = 1'b0;
    logic [1:0]  cfg_wsize = 2'd0;
    logic        cfg_stride = 1'b0;
    logic [1:0]  cfg_padding = 2'd0;
    logic [15:0] cfg_w_base = 16'd0, cfg_i_base = 16'd0;
    logic        busy, done, err, mem_rd_en;
    logic [15:0] mem_addr;
    logic [63:0] mem_rdata = 64'd0;
    logic        ipf_w_valid, ipf_i_valid, ipf_stride;
    logic [63:0] ipf_w_data, ipf_i_data;
    logic [1:0]  ipf_ctrl, ipf_wsize, ipf_rlpadding;
    logic [3:0]  ipf_wgroup;
    logic [2:0]  ipf_wround;
    logic        ipf_finish = 1'b0;

    ipf_sequencer #(.AW(16), .DW(64), .DRAIN(10), .FIN_TO(1024)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_wsize(cfg_wsize), .cfg_stride(cfg_stride), .cfg_padding(cfg_padding),
        .cfg_w_base(cfg_w_base), .cfg_i_base(cfg_i_base),
        .busy(busy), .done(done), .err(err),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .ipf_w_valid(ipf_w_valid), .ipf_w_data(ipf_w_data),
        .ipf_i_valid(ipf_i_valid), .ipf_i_data(ipf_i_data),
        .ipf_ctrl(ipf_ctrl), .ipf_wsize(ipf_wsize), .ipf_stride(ipf_stride),
        .ipf_rlpadding(ipf_rlpadding), .ipf_wgroup(ipf_wgroup), .ipf_wround(ipf_wround),
        .ipf_finish(ipf_finish)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] memval(input logic [15:0] a);
        return {a ^ 16'hA5C3, ~a, a, a + 16'h1234};
    endfunction

    always @(posedge clk) mem_rdata <= mem_rd_en ? memval(mem_addr) : 64'd0;

    // beat = {w_valid, i_valid, ctrl, wgroup, wround, data}
    logic [74:0] exp_q[$];
    int n_chk = 0, n_pass = 0;
    int cyc = 0, n_w = 0, n_i = 0, n_start = 0, n_rd = 0, n_done = 0, n_err = 0, n_endc = 0;
    int last_vld = 0, end_gap = -1;
    logic [1:0] prev_ctrl = 2'd2;

    task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [191:0] out_vec();
        return 192'({busy, done, err, mem_rd_en, mem_addr, ipf_w_valid, ipf_i_valid,
                     ipf_w_data, ipf_i_data, ipf_ctrl, ipf_wsize, ipf_stride,
                     ipf_rlpadding, ipf_wgroup, ipf_wround});
    endfunction

    // Every cycle passes through here: sample after the edge, compare beats, update counters.
    task automatic tick();
        logic [74:0] b;
        @(posedge clk);
        #1;
        cyc++;
        if (ipf_w_valid || ipf_i_valid) begin
            b = {ipf_w_valid, ipf_i_valid, ipf_ctrl, ipf_wgroup, ipf_wround,
                 ipf_w_valid ? ipf_w_data : ipf_i_data};
            if (exp_q.size() == 0) chk("beat_unexpected", 192'(b), 192'(0));
            else chk("beat", 192'(b), 192'(exp_q.pop_front()));
            last_vld = cyc;
        end
        if (ipf_w_valid) n_w++;
        if (ipf_i_valid) n_i++;
        if (ipf_ctrl == 2'd1) n_start++;
        if (ipf_ctrl == 2'd0) n_endc++;
        if (mem_rd_en) n_rd++;
        if (done) n_done++;
        if (err) n_err++;
        if (ipf_ctrl == 2'd0 && prev_ctrl != 2'd0) end_gap = cyc - last_vld - 1;
        prev_ctrl = ipf_ctrl;
    endtask

    task automatic push_job(input int ws, input int st, input logic [15:0] wb, input logic [15:0] ib,
                            output int ew, output int ei, output int es);
        int p, np, c, wg, wr;
        ew = (ws == 0) ? 18 : 25;
        p  = (ws == 0) ? 2 : (ws == 1) ? 4 : 6;
        np = (st != 0) ? 1 : (ws == 2) ? 4 : 2;
        ei = 8 * np;
        es = np * (8 - p);
        for (int k = 0; k < ew; k++)
            exp_q.push_back({1'b1, 1'b0, 2'd2, 4'd0, 3'd0, memval(wb + 16'(k))});
        for (int ps = 0; ps < np; ps++)
            for (int j = 0; j < 8; j++) begin
                c  = (j < p) ? 2 : 1;
                wg = (st != 0) ? ((j < p) ? 0 : (j - p) % 2) : ((ws == 0) ? ps : 0);
                wr = (st == 0 && ws != 0) ? ps : 0;
                exp_q.push_back({1'b0, 1'b1, 2'(c), 4'(wg), 3'(wr), memval(ib + 16'(j))});
            end
    endtask

    task automatic do_start(input int ws, input int st, input logic [15:0] wb, input logic [15:0] ib);
        cfg_wsize = 2'(ws); cfg_stride = 1'(st); cfg_padding = 2'd1;
        cfg_w_base = wb; cfg_i_base = ib;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        bit seen = 0;
        for (int k = 0; k < 600 && !seen; k++) begin
            tick();
            if (ipf_ctrl == 2'd0) seen = 1;
        end
        chk(tag, 192'(seen), 192'(1));
    endtask

    task automatic run_job(input int ws, input int st, input logic [15:0] wb, input logic [15:0] ib,
                           input bit early_fin, input bit extra_start);
        int ew, ei, es, w0, i0, s0, d0, e0;
        w0 = n_w; i0 = n_i; s0 = n_start; d0 = n_done; e0 = n_err;
        push_job(ws, st, wb, ib, ew, ei, es);
        do_start(ws, st, wb, ib);
        chk("busy_on_start", 192'(busy), 192'(1));
        if (early_fin) begin
            ipf_finish = 1'b1; tick(); ipf_finish = 1'b0;
        end
        if (extra_start) begin
            tick();
            cfg_wsize = 2'd0; cfg_w_base = 16'h3000; start = 1'b1;
            tick();
            start = 1'b0;
        end
        wait_end("end_seen");
        tick(); tick();
        ipf_finish = 1'b1; tick(); ipf_finish = 1'b0;
        chk("done_pulse", 192'({done, busy, err, ipf_ctrl}), 192'({1'b1, 1'b0, 1'b0, 2'd2}));
        tick();
        chk("done_one_cycle", 192'(done), 192'(0));
        chk("queue_drained", 192'(exp_q.size()), 192'(0));
        chk("w_words", 192'(n_w - w0), 192'(ew));
        chk("i_words", 192'(n_i - i0), 192'(ei));
        chk("start_cycles", 192'(n_start - s0), 192'(es));
        chk("drain_gap", 192'(end_gap), 192'(10));
        chk("done_count", 192'({n_done - d0, n_err - e0}), 192'({32'd1, 32'd0}));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ew, ei, es, r0, e0, d0, i0, s0, c0;
        bit hit;
        tick(); tick();
        chk("reset_outputs", out_vec(), 192'h2000);
        rst = 1'b1;
        tick();

        run_job(0, 0, 16'h0100, 16'h0000, 1'b1, 1'b0);   // 3x3 s1, stray finish during load
        run_job(2, 0, 16'hFFF0, 16'h0200, 1'b0, 1'b1);   // 7x7 s1, weight reads wrap, start while busy
        run_job(1, 1, 16'h0300, 16'hFFFC, 1'b0, 1'b0);   // 5x5 s2, input reads wrap

        r0 = n_rd; e0 = n_err;
        do_start(3, 0, 16'h0100, 16'h0000);
        chk("illegal_err", 192'({err, busy}), 192'({1'b1, 1'b0}));
        tick(); tick(); tick();
        chk("illegal_quiet", 192'({n_rd - r0, n_err - e0, 31'd0, busy}), 192'({32'd0, 32'd1, 32'd0}));

        r0 = n_rd;
        cfg_wsize = 2'd1; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        tick(); tick();
        chk("abort_beats_start", 192'({n_rd - r0, 31'd0, busy}), 192'(0));

        push_job(1, 0, 16'h0400, 16'h0500, ew, ei, es);
        do_start(1, 0, 16'h0400, 16'h0500);
        s0 = n_start; d0 = n_done; hit = 0;
        for (int k = 0; k < 200 && !hit; k++) begin
            tick();
            if (n_start - s0 == 5) hit = 1;
        end
        chk("reach_pass1_run", 192'(hit), 192'(1));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_end", 192'({ipf_ctrl, ipf_w_valid, ipf_i_valid, mem_rd_en, busy, done, err}),
            192'({2'd0, 6'd0}));
        exp_q.delete();
        i0 = n_i;
        tick();
        chk("abort_hold", 192'({ipf_ctrl, busy}), 192'({2'd2, 1'b0}));
        for (int k = 0; k < 5; k++) tick();
        chk("abort_quiet", 192'({n_i - i0, n_done - d0}), 192'(0));
        run_job(1, 0, 16'h0400, 16'h0500, 1'b0, 1'b0);

        c0 = n_endc; d0 = n_done; e0 = n_err;
        push_job(0, 1, 16'h0700, 16'h0800, ew, ei, es);
        do_start(0, 1, 16'h0700, 16'h0800);
        wait_end("timeout_end_seen");
        hit = 0;
        for (int k = 0; k < 1200 && !hit; k++) begin
            tick();
            if (err) hit = 1;
        end
        chk("timeout_err", 192'({hit, busy, ipf_ctrl}), 192'({1'b1, 1'b0, 2'd2}));
        chk("timeout_len", 192'((n_endc - c0 >= 1023) && (n_endc - c0 <= 1024)), 192'(1));
        chk("timeout_no_done", 192'({n_done - d0, n_err - e0}), 192'({32'd0, 32'd1}));
        chk("timeout_queue", 192'(exp_q.size()), 192'(0));

        push_job(2, 0, 16'h0900, 16'h0A00, ew, ei, es);
        do_start(2, 0, 16'h0900, 16'h0A00);
        tick(); tick(); tick();
        chk("mid_load", 192'({busy, ipf_w_valid}), 192'({1'b1, 1'b1}));
        #2 rst = 1'b0;
        #1;
        chk("async_reset", out_vec(), 192'h2000);
        exp_q.delete();
        tick(); tick();
        rst = 1'b1;
        tick(); tick();
        chk("post_reset_idle", 192'({busy, mem_rd_en, ipf_ctrl}), 192'({1'b0, 1'b0, 2'd2}));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
